// File: rtl/matmul_pkg.sv
// Shared types and sizing constants for the matmul scheduler and its
// write-back address generator.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int MAX_DIM = 4;
    localparam int DIM_W   = 2;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/matmul_wb_addr_gen.sv
// Row-major write-back iterator: walks (row, col) over the N x M result and
// presents the flattened element index row*MAX_DIM + col as a registered output.
module matmul_wb_addr_gen
    import matmul_pkg::*;
#(
    parameter int MAX_DIM_P = MAX_DIM
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] n_m1_i,
    input  logic [DIM_W-1:0] m_m1_i,
    output logic [CNT_W-1:0] elem_o,
    output logic             last_o
);

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] elem_q, elem_d;

    assign last_o = (row_q == n_m1_i) && (col_q == m_m1_i);
    assign elem_o = elem_q;

    // Wrapping to (0,0) after the final element leaves the index at 0 outside write-back.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (init_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (last_o) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == m_m1_i) begin
                row_d = row_q + 1'b1;
                col_d = '0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        elem_d = CNT_W'(row_d) * CNT_W'(MAX_DIM_P) + CNT_W'(col_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q  <= '0;
            col_q  <= '0;
            elem_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            elem_q <= elem_d;
        end
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequencer for a systolic matrix multiply: clears the PE array, feeds it,
// drains it, then writes the N x M result to a scratchpad target under grant.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int SP_NTARGETS = 4,
    localparam int TGT_W      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic [TGT_W-1:0] target_i,
    input  logic             sp_gnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             start_ovr_o,
    output logic             pe_clear_o,
    output logic             pe_en_o,
    output logic [CNT_W-1:0] feed_cnt_o,
    output logic             sp_req_o,
    output logic [TGT_W-1:0] sp_target_o,
    output logic [CNT_W-1:0] sp_elem_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    state_e           state_q;
    logic [DIM_W-1:0] n_q, m_q, k_q;
    logic [TGT_W-1:0] tgt_q;
    logic [CNT_W-1:0] feed_q;
    logic             busy_q, done_q, ovr_q, clr_q, en_q, req_q;
    logic [TGT_W-1:0] sp_tgt_q;

    logic             wb_adv;
    logic             wb_last;
    logic             feed_last;

    assign wb_adv = req_q & sp_gnt_i;
    // Dimensions are held minus one, so L-1 = K+N+M-3 is simply their sum.
    assign feed_last = (feed_q == (CNT_W'(n_q) + CNT_W'(m_q) + CNT_W'(k_q)));

    matmul_wb_addr_gen #(
        .MAX_DIM_P (MAX_DIM)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .init_i (state_q != WB),
        .adv_i  (wb_adv),
        .n_m1_i (n_q),
        .m_m1_i (m_q),
        .elem_o (sp_elem_o),
        .last_o (wb_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            n_q      <= '0;
            m_q      <= '0;
            k_q      <= '0;
            tgt_q    <= '0;
            feed_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            req_q    <= 1'b0;
            sp_tgt_q <= '0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= start_i && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q     <= n_dim_i;
                        m_q     <= m_dim_i;
                        k_q     <= k_dim_i;
                        tgt_q   <= target_i;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    en_q    <= 1'b1;
                    feed_q  <= '0;
                    state_q <= FEED;
                end
                FEED: begin
                    if (feed_last) begin
                        feed_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        feed_q <= feed_q + 1'b1;
                    end
                end
                DRAIN: begin
                    en_q     <= 1'b0;
                    req_q    <= 1'b1;
                    sp_tgt_q <= tgt_q;
                    state_q  <= WB;
                end
                WB: begin
                    if (wb_adv && wb_last) begin
                        req_q    <= 1'b0;
                        sp_tgt_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign start_ovr_o = ovr_q;
    assign pe_clear_o  = clr_q;
    assign pe_en_o     = en_q;
    assign feed_cnt_o  = feed_q;
    assign sp_req_o    = req_q;
    assign sp_target_o = sp_tgt_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler: cycle-by-cycle expected output tables
// for full, minimal, stalled, overlapping-start and reset-during-write runs.
module tb_matmul_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] n_dim_i = '0, m_dim_i = '0, k_dim_i = '0;
    logic [1:0] target_i = '0;
    logic       sp_gnt_i = 1'b1;
    logic       busy_o, done_o, start_ovr_o, pe_clear_o, pe_en_o, sp_req_o;
    logic [3:0] feed_cnt_o, sp_elem_o;
    logic [1:0] sp_target_o;

    int checks = 0;
    int errors = 0;

    matmul_scheduler dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .n_dim_i     (n_dim_i),
        .m_dim_i     (m_dim_i),
        .k_dim_i     (k_dim_i),
        .target_i    (target_i),
        .sp_gnt_i    (sp_gnt_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .start_ovr_o (start_ovr_o),
        .pe_clear_o  (pe_clear_o),
        .pe_en_o     (pe_en_o),
        .feed_cnt_o  (feed_cnt_o),
        .sp_req_o    (sp_req_o),
        .sp_target_o (sp_target_o),
        .sp_elem_o   (sp_elem_o)
    );

    always #5 clk_i = ~clk_i;

    // Layout {busy,done,ovr,clr,en,req,feed[3:0],elem[3:0],tgt[1:0]}
    function automatic logic [15:0] obs();
        return {busy_o, done_o, start_ovr_o, pe_clear_o, pe_en_o, sp_req_o,
                feed_cnt_o, sp_elem_o, sp_target_o};
    endfunction

    function automatic logic [15:0] pack(input logic b, input logic d, input logic o,
                                         input logic c, input logic e, input logic r,
                                         input int f, input int el, input int t);
        return {b, d, o, c, e, r, 4'(f), 4'(el), 2'(t)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        #1;
        got = obs();
        checks++;
        if (got !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", got, 16'h0);
        end
        repeat (2) tick();
        got = obs();
        checks++;
        if (got !== 16'h0) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", got, 16'h0);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_full_4x4();
        logic [15:0] got, exp;
        n_dim_i = 2'd3; m_dim_i = 2'd3; k_dim_i = 2'd3; target_i = 2'd1;
        sp_gnt_i = 1'b1; start_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start_i = 1'b0;
            exp = pack(c >= 1 && c <= 28, c == 29, 1'b0, c == 1, c >= 2 && c <= 12,
                       c >= 13 && c <= 28, (c >= 2 && c <= 11) ? c - 2 : 0,
                       (c >= 13 && c <= 28) ? c - 13 : 0, (c >= 13 && c <= 28) ? 1 : 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL full_4x4 cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_1x1();
        logic [15:0] got, exp;
        n_dim_i = 2'd0; m_dim_i = 2'd0; k_dim_i = 2'd0; target_i = 2'd0;
        sp_gnt_i = 1'b1; start_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_i = 1'b0;
            exp = pack(c >= 1 && c <= 4, c == 5, 1'b0, c == 1, c == 2 || c == 3,
                       c == 4, 0, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL min_1x1 cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] got, exp;
        int el;
        n_dim_i = 2'd1; m_dim_i = 2'd1; k_dim_i = 2'd0; target_i = 2'd0;
        sp_gnt_i = 1'b1; start_i = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start_i = 1'b0;
            case (c)
                7, 8, 9, 10: el = 1;
                11:          el = 4;
                12:          el = 5;
                default:     el = 0;
            endcase
            exp = pack(c >= 1 && c <= 12, c == 13, 1'b0, c == 1, c >= 2 && c <= 5,
                       c >= 6 && c <= 12, (c >= 2 && c <= 4) ? c - 2 : 0, el, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_grant cycle=%0d got=%b exp=%b", c, got, exp);
            end
            sp_gnt_i = !(c >= 7 && c <= 9);
        end
        sp_gnt_i = 1'b1;
    endtask

    task automatic test_start_overlap();
        logic [15:0] got, exp;
        int el;
        n_dim_i = 2'd1; m_dim_i = 2'd1; k_dim_i = 2'd1; target_i = 2'd2;
        sp_gnt_i = 1'b1; start_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            case (c)
                8:       el = 1;
                9:       el = 4;
                10:      el = 5;
                default: el = 0;
            endcase
            exp = pack(c >= 1 && c <= 10, c == 11, c == 4 || c == 12, c == 1,
                       c >= 2 && c <= 6, c >= 7 && c <= 10,
                       (c >= 2 && c <= 5) ? c - 2 : 0, el, (c >= 7 && c <= 10) ? 2 : 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL start_overlap cycle=%0d got=%b exp=%b", c, got, exp);
            end
            start_i = (c == 3) || (c == 11);
            if (c >= 3) begin
                n_dim_i = 2'd3; m_dim_i = 2'd3; k_dim_i = 2'd3; target_i = 2'd3;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid_wb();
        logic [15:0] got;
        n_dim_i = 2'd3; m_dim_i = 2'd3; k_dim_i = 2'd3; target_i = 2'd1;
        sp_gnt_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        got = obs();
        checks++;
        if (got !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1)) begin
            errors++;
            $display("FAIL pre_reset_wb got=%b exp=%b", got,
                     pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1));
        end
        #2 rst_i = 1'b1;
        #1;
        got = obs();
        checks++;
        if (got !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_wb got=%b exp=%b", got, 16'h0);
        end
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_4x4();
        test_1x1();
        test_stall();
        test_start_overlap();
        test_reset_mid_wb();
        test_1x1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_scheduler.md
MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand element width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: result element width.
REQ-003 SHALL have parameter SP_NTARGETS, default 4: number of scratchpad targets.
REQ-004 SHALL have derived constant MAX_DIM = BUS_WIDTH/DATA_WIDTH, which is 4 with the defaults.
REQ-005 SHALL have a single clock and asynchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  reset.
REQ-006 Control ports: start_i  in  1  start pulse from control register; n_dim_i, m_dim_i, k_dim_i  in  2 each  dimension minus 1.
REQ-007 Target port: target_i  in  clog2(SP_NTARGETS)  result target.
REQ-008 Grant port: sp_gnt_i  in  1  scratchpad write grant.
REQ-009 Status outputs: busy_o  out  1; done_o  out  1  one-cycle pulse; start_ovr_o  out  1  one-cycle pulse on start while busy.
REQ-010 Datapath outputs: pe_clear_o  out  1  clear accumulators; pe_en_o  out  1  advance array; feed_cnt_o  out  4  feed cycle index.
REQ-011 Scratchpad outputs: sp_req_o  out  1  write request; sp_target_o  out  clog2(SP_NTARGETS); sp_elem_o  out  4  element index row*MAX_DIM+col.

Function
REQ-012 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, WB, DONE.
REQ-013 IDLE: start_i=1 SHALL latch N=n_dim_i+1, M=m_dim_i+1, K=k_dim_i+1 and target_i, then go to CLEAR.
REQ-014 Config inputs changing after the start cycle SHALL have no effect until the next accepted start.
REQ-015 CLEAR SHALL last exactly 1 cycle with pe_clear_o=1, then go to FEED.
REQ-016 FEED SHALL last L=K+N+M-2 cycles with pe_en_o=1 and feed_cnt_o counting 0..L-1, then go to DRAIN.
REQ-017 DRAIN SHALL last 1 cycle with pe_en_o=1 and feed_cnt_o=0, then go to WB.
REQ-018 WB SHALL assert sp_req_o and iterate row 0..N-1 (outer) and col 0..M-1 (inner).
REQ-019 WB SHALL advance the element index only in a cycle with sp_req_o=1 and sp_gnt_i=1, and SHALL hold sp_elem_o stable otherwise.
REQ-020 WB SHALL go to DONE on the cycle after the grant of element (N-1,M-1).
REQ-021 sp_target_o SHALL equal the latched target during WB and be 0 otherwise.
REQ-022 DONE SHALL last 1 cycle with done_o=1 and busy_o=0, then go to IDLE.
REQ-023 busy_o SHALL be 1 in CLEAR, FEED, DRAIN and WB only.
REQ-024 start_i=1 in any state other than IDLE SHALL be ignored and SHALL pulse start_ovr_o in the following cycle.
REQ-025 start_i=1 in DONE SHALL be ignored and SHALL pulse start_ovr_o.
REQ-026 All outputs SHALL be registered; sp_elem_o = row*MAX_DIM + col with no wrap beyond MAX_DIM*MAX_DIM-1.

Reset
REQ-027 rst_i=1 SHALL asynchronously force state IDLE and all outputs to 0, including mid-FEED and mid-WB with an outstanding request.
REQ-028 rst_i=1 SHALL clear all latched config.
REQ-029 The first accepted start after rst_i deasserts SHALL behave as in REQ-013.

Structure
REQ-030 Package matmul_pkg SHALL hold the state enum, MAX_DIM, the dimension width (2) and the counter width (4).
REQ-031 Row/col iteration and sp_elem_o generation SHALL be in sub-module matmul_wb_addr_gen, which takes an advance strobe and N/M and returns a last flag.

Verification
REQ-032 N=M=K=4, sp_gnt_i=1, start in cycle 0 -> pe_clear_o in cycle 1, pe_en_o in cycles 2-12, sp_req_o in cycles 13-28 with sp_elem_o 0..15, done_o in cycle 29.
REQ-033 N=M=K=1 -> CLEAR in cycle 1, FEED in cycle 2, DRAIN in cycle 3, single write of sp_elem_o=0 in cycle 4, done_o in cycle 5.
REQ-034 N=M=2, K=1, sp_gnt_i low for 3 cycles at the second element -> sp_elem_o holds 1 for 4 cycles, sequence is 0,1,4,5, and done_o comes 3 cycles later than with no stall.
REQ-035 start_i pulsed in FEED with different dims -> start_ovr_o pulses once and the run completes with the original dims.
REQ-036 rst_i asserted mid-WB -> sp_req_o, busy_o and sp_elem_o are 0 immediately; a new start then runs cleanly.
REQ-037 target_i=2 at start and changed to 3 during FEED -> sp_target_o=2 throughout WB.
